// File: rtl/swm_pkg.sv
// Shared types for the SerialLite III RX adapter: fill pattern,
// receive FSM states and the FIFO entry layout.
package swm_pkg;

    localparam logic [223:0] FILL_PATTERN = {28{8'hbc}};

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DROP
    } rx_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        error;
    } rx_beat_t;

endpackage

// File: rtl/swm_rx_fifo.sv
// Show-ahead FIFO of rx beats; head is readable combinationally
// and occupancy is exported so the writer can reserve a slot.
module swm_rx_fifo
    import swm_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  rx_beat_t                      wdata_i,
    input  logic                          pop_i,
    output rx_beat_t                      rdata_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_beat_t       mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_q, wr_d;
    logic [AW:0]    rd_q, rd_d;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign count_o = wr_q - rd_q;
    assign valid_o = (count_o != '0);
    assign full    = (count_o == (AW+1)'(FIFO_DEPTH));
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && valid_o;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // Advance pointers on accepted push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/swm_rx_adapter.sv
// SL3 RX burst to Avalon-ST packet adapter with framing FSM and stats.
// Optional fill-pattern check enabled by SWM_RX_PATTERN_CHECK_EN.
module swm_rx_adapter
    import swm_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk_in_clk,
    input  logic             reset_in_rst_n,
    input  logic [255:0]     data_rx,
    input  logic             valid_rx,
    input  logic             start_of_burst_rx,
    input  logic             end_of_burst_rx,
    input  logic [7:0]       sync_rx,
    input  logic [3:0]       error_rx,
    output logic [31:0]      avalonst_source_data,
    output logic             avalonst_source_valid,
    output logic             avalonst_source_startofpacket,
    output logic             avalonst_source_endofpacket,
    output logic             avalonst_source_error,
    input  logic             avalonst_source_ready,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] overflow_count,
    output logic [CNT_W-1:0] framing_err_count,
    output logic [CNT_W-1:0] pattern_err_count,
    output logic [3:0]       link_err_sticky
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] ROOM_LIM = OCC_W'(FIFO_DEPTH - 1);

    rx_state_e        state_q, state_d;
    rx_beat_t         wbeat;
    rx_beat_t         term;
    rx_beat_t         head;
    logic             push;
    logic             head_vld;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic             room;
    logic             pat_err;
    logic             beat_err;
    logic             ovf_inc;
    logic             frm_inc;
    logic             unused_bits;

    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [3:0]       sticky_q, sticky_d;

    assign room     = (occ < ROOM_LIM);
    assign beat_err = (|error_rx) | pat_err;
    assign term     = '{data: 32'h0, sop: 1'b0, eop: 1'b1, error: 1'b1};

`ifdef SWM_RX_PATTERN_CHECK_EN
    logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;

    assign pat_err     = valid_rx && (data_rx[255:32] != FILL_PATTERN);
    assign unused_bits = ^sync_rx;

    // Saturating fill-pattern mismatch counter; clear wins.
    always_comb begin
        pat_cnt_d = pat_cnt_q;
        if (clear_stats)
            pat_cnt_d = '0;
        else if (pat_err && !(&pat_cnt_q))
            pat_cnt_d = pat_cnt_q + CNT_W'(1);
    end

    // Pattern counter register.
    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) pat_cnt_q <= '0;
        else                 pat_cnt_q <= pat_cnt_d;
    end

    assign pattern_err_count = pat_cnt_q;
`else
    assign pat_err           = 1'b0;
    assign unused_bits       = ^{sync_rx, data_rx[255:32]};
    assign pattern_err_count = '0;
`endif

    // Framing FSM: decides push, terminator insertion and fault counts.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        wbeat   = '0;
        ovf_inc = 1'b0;
        frm_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_rx) begin
                    if (start_of_burst_rx) begin
                        if (room) begin
                            push  = 1'b1;
                            wbeat = '{data: data_rx[31:0], sop: 1'b1,
                                      eop: end_of_burst_rx,
                                      error: beat_err};
                            if (!end_of_burst_rx) state_d = IN_PKT;
                        end else begin
                            ovf_inc = 1'b1;
                            if (!end_of_burst_rx) state_d = DROP;
                        end
                    end else begin
                        frm_inc = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (valid_rx) begin
                    if (start_of_burst_rx) begin
                        push    = 1'b1;
                        wbeat   = term;
                        frm_inc = 1'b1;
                        state_d = end_of_burst_rx ? IDLE : DROP;
                    end else if (room) begin
                        push  = 1'b1;
                        wbeat = '{data: data_rx[31:0], sop: 1'b0,
                                  eop: end_of_burst_rx,
                                  error: beat_err};
                        if (end_of_burst_rx) state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        wbeat   = term;
                        ovf_inc = 1'b1;
                        state_d = end_of_burst_rx ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (valid_rx && end_of_burst_rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    // Saturating counters and sticky link errors; clear wins.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        frm_cnt_d = frm_cnt_q;
        sticky_d  = sticky_q | error_rx;
        if (clear_stats) begin
            ovf_cnt_d = '0;
            frm_cnt_d = '0;
            sticky_d  = '0;
        end else begin
            if (ovf_inc && !(&ovf_cnt_q))
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            if (frm_inc && !(&frm_cnt_q))
                frm_cnt_d = frm_cnt_q + CNT_W'(1);
        end
    end

    // Status registers.
    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) begin
            ovf_cnt_q <= '0;
            frm_cnt_q <= '0;
            sticky_q  <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    assign overflow_count    = ovf_cnt_q;
    assign framing_err_count = frm_cnt_q;
    assign link_err_sticky   = sticky_q;

    swm_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in_clk),
        .rst_ni  (reset_in_rst_n),
        .push_i  (push),
        .wdata_i (wbeat),
        .pop_i   (pop),
        .rdata_o (head),
        .valid_o (head_vld),
        .count_o (occ)
    );

    assign pop = head_vld && avalonst_source_ready;

    // Source side is forced low while the FIFO is empty.
    assign avalonst_source_valid         = head_vld;
    assign avalonst_source_data          = head_vld ? head.data : '0;
    assign avalonst_source_startofpacket = head_vld && head.sop;
    assign avalonst_source_endofpacket   = head_vld && head.eop;
    assign avalonst_source_error         = head_vld && head.error;

endmodule

// File: tb/tb_swm_rx_adapter.sv
// Directed bench for swm_rx_adapter (FIFO_DEPTH=64, CNT_W=16).
// Inputs driven 1 time unit after the rising edge; outputs read there.
module tb_swm_rx_adapter;
    import swm_pkg::*;

`ifdef SWM_RX_PATTERN_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] data_rx;
    logic         valid_rx;
    logic         sob;
    logic         eob;
    logic [7:0]   sync_rx;
    logic [3:0]   error_rx;
    logic [31:0]  src_data;
    logic         src_valid;
    logic         src_sop;
    logic         src_eop;
    logic         src_err;
    logic         src_ready;
    logic         clear_stats;
    logic [15:0]  ovf_cnt;
    logic [15:0]  frm_cnt;
    logic [15:0]  pat_cnt;
    logic [3:0]   sticky;

    int n_vec = 0;
    int n_err = 0;

    swm_rx_adapter #(
        .FIFO_DEPTH (64),
        .CNT_W      (16)
    ) dut (
        .clk_in_clk                    (clk),
        .reset_in_rst_n                (rst_n),
        .data_rx                       (data_rx),
        .valid_rx                      (valid_rx),
        .start_of_burst_rx             (sob),
        .end_of_burst_rx               (eob),
        .sync_rx                       (sync_rx),
        .error_rx                      (error_rx),
        .avalonst_source_data          (src_data),
        .avalonst_source_valid         (src_valid),
        .avalonst_source_startofpacket (src_sop),
        .avalonst_source_endofpacket   (src_eop),
        .avalonst_source_error         (src_err),
        .avalonst_source_ready         (src_ready),
        .clear_stats                   (clear_stats),
        .overflow_count                (ovf_cnt),
        .framing_err_count             (frm_cnt),
        .pattern_err_count             (pat_cnt),
        .link_err_sticky               (sticky)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_src(input string tag, input logic v,
                           input logic [31:0] d, input logic s,
                           input logic e, input logic er);
        chk(tag, 64'({src_valid, src_sop, src_eop, src_err, src_data}),
                 64'({v, s, e, er, d}));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat_raw(input logic s, input logic e,
                            input logic [255:0] d, input logic [3:0] er);
        valid_rx = 1'b1;
        sob      = s;
        eob      = e;
        data_rx  = d;
        error_rx = er;
        tick(1);
        valid_rx = 1'b0;
        sob      = 1'b0;
        eob      = 1'b0;
        error_rx = 4'h0;
    endtask

    task automatic beat(input logic s, input logic e,
                        input logic [31:0] d, input logic [3:0] er);
        beat_raw(s, e, {FILL_PATTERN, d}, er);
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
    endtask

    initial begin
        logic [255:0] bad;

        rst_n       = 1'b0;
        data_rx     = '0;
        valid_rx    = 1'b0;
        sob         = 1'b0;
        eob         = 1'b0;
        sync_rx     = 8'h0;
        error_rx    = 4'h0;
        src_ready   = 1'b0;
        clear_stats = 1'b0;
        tick(2);

        chk_src("rst_src", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_cnt", 64'({ovf_cnt, frm_cnt, pat_cnt, sticky}), 64'h0);
        rst_n = 1'b1;
        tick(1);

        // 3-beat burst streamed through with ready high
        src_ready = 1'b1;
        beat(1'b1, 1'b0, 32'd1, 4'h0);
        chk_src("t1_b1", 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 32'd2, 4'h0);
        chk_src("t1_b2", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 32'd3, 4'h0);
        chk_src("t1_b3", 1'b1, 32'd3, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_src("t1_empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // stray beat in IDLE
        beat(1'b0, 1'b0, 32'h55, 4'h0);
        chk_src("t3_nopush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3_frm", 64'(frm_cnt), 64'd1);
        pulse_clear();
        chk("t3_clr", 64'(frm_cnt), 64'd0);

        // clear coinciding with a framing increment
        clear_stats = 1'b1;
        beat(1'b0, 1'b0, 32'h66, 4'h0);
        clear_stats = 1'b0;
        chk("clr_wins", 64'(frm_cnt), 64'd0);

        // SOB mid-packet: terminator, DROP until EOB, next burst ok
        src_ready = 1'b0;
        beat(1'b1, 1'b0, 32'd10, 4'h0);
        beat(1'b0, 1'b0, 32'd11, 4'h0);
        beat(1'b1, 1'b0, 32'd12, 4'h0);
        beat(1'b1, 1'b0, 32'd13, 4'h0);
        beat(1'b0, 1'b1, 32'd14, 4'h0);
        beat(1'b1, 1'b1, 32'd20, 4'h0);
        chk("t4_frm", 64'(frm_cnt), 64'd1);
        chk("t4_ovf", 64'(ovf_cnt), 64'd0);
        src_ready = 1'b1;
        chk_src("t4_h10", 1'b1, 32'd10, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_src("t4_h11", 1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_src("t4_term", 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
        tick(1);
        chk_src("t4_h20", 1'b1, 32'd20, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_src("t4_empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        pulse_clear();

        // link error on beat 2 and sticky clear
        src_ready = 1'b0;
        beat(1'b1, 1'b0, 32'd1, 4'h0);
        beat(1'b0, 1'b0, 32'd2, 4'b0010);
        beat(1'b0, 1'b1, 32'd3, 4'h0);
        chk("t5_sticky", 64'(sticky), 64'h2);
        src_ready = 1'b1;
        chk_src("t5_b1", 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_src("t5_b2", 1'b1, 32'd2, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_src("t5_b3", 1'b1, 32'd3, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_src("t5_empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        pulse_clear();
        chk("t5_clr", 64'(sticky), 64'h0);
        error_rx = 4'b1000;
        tick(1);
        error_rx = 4'h0;
        chk("t5_idle_err", 64'(sticky), 64'h8);
        pulse_clear();

        // 80-beat burst into a stalled 64-deep FIFO
        src_ready = 1'b0;
        for (int i = 0; i < 80; i++)
            beat(i == 0, i == 79, 32'(i + 1), 4'h0);
        chk("t2_ovf", 64'(ovf_cnt), 64'd1);
        chk("t2_frm", 64'(frm_cnt), 64'd0);
        src_ready = 1'b1;
        for (int i = 0; i < 63; i++) begin
            chk_src($sformatf("t2_d%0d", i), 1'b1, 32'(i + 1),
                    i == 0, 1'b0, 1'b0);
            tick(1);
        end
        chk_src("t2_term", 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
        tick(1);
        chk_src("t2_empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 32'd100, 4'h0);
        chk_src("t2_n1", 1'b1, 32'd100, 1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 32'd101, 4'h0);
        chk_src("t2_n2", 1'b1, 32'd101, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_src("t2_empty2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t2_ovf_hold", 64'(ovf_cnt), 64'd1);

        // fill pattern corrupted in bits [63:32]
        src_ready = 1'b0;
        bad = {FILL_PATTERN, 32'h77};
        bad[63:32] = 32'h0;
        beat_raw(1'b1, 1'b1, bad, 4'h0);
        chk("t6_pcnt", 64'(pat_cnt), 64'(PC));
        chk_src("t6_beat", 1'b1, 32'h77, 1'b1, 1'b1, PC);

        // reset with data queued discards it
        beat(1'b1, 1'b0, 32'd9, 4'h0);
        rst_n = 1'b0;
        #1;
        chk_src("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk_src("rst_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 32'd5, 4'h0);
        chk("rst_idle", 64'(frm_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
